// File: rtl/character_motion_fsm.sv
// Per-character motion/attack sequencer: walks, clamps and attacks once per
// enabled frame tick; all outputs come straight from registers.
module character_motion_fsm #(
    parameter logic [9:0] X_MIN           = 10'd0,
    parameter logic [9:0] X_MAX           = 10'd576,
    parameter logic [9:0] X_START         = 10'd64,
    parameter logic       FACING_INIT     = 1'b1,
    parameter logic [9:0] STEP            = 10'd4,
    parameter logic [3:0] WALK_DIV        = 4'd6,
    parameter logic [3:0] ATTACK_FRAMES   = 4'd8,
    parameter logic [3:0] HIT_FIRST       = 4'd3,
    parameter logic [3:0] HIT_LAST        = 4'd5,
    parameter logic [3:0] COOLDOWN_FRAMES = 4'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       game_en_i,
    input  logic       move_l_i,
    input  logic       move_r_i,
    input  logic       attack_i,
    output logic [9:0] pos_x_o,
    output logic       facing_o,
    output logic [1:0] state_o,
    output logic [3:0] anim_frame_o,
    output logic       hit_active_o,
    output logic       busy_o
);
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_WALK   = 2'b01;
    localparam logic [1:0] S_ATTACK = 2'b10;
    localparam logic [1:0] S_COOL   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic        facing_q, facing_d;
    logic        armed_q, armed_d;
    logic [3:0]  atk_cnt_q, atk_cnt_d;
    logic [3:0]  cd_cnt_q, cd_cnt_d;
    logic [3:0]  walk_cnt_q, walk_cnt_d;
    logic [1:0]  walk_ph_q, walk_ph_d;
    logic [3:0]  anim_q, anim_d;
    logic        hit_q, hit_d;
    logic        upd_s;
    logic [10:0] right_sum_s;
    logic [10:0] left_lim_s;

    assign upd_s       = frame_tick_i & game_en_i;
    assign right_sum_s = {1'b0, pos_x_q} + {1'b0, STEP};
    assign left_lim_s  = {1'b0, X_MIN} + {1'b0, STEP};

    // Next-state logic; walk counters are kept at zero whenever the next state is not WALK.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        facing_d   = facing_q;
        armed_d    = armed_q;
        atk_cnt_d  = atk_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        walk_cnt_d = walk_cnt_q;
        walk_ph_d  = walk_ph_q;
        if (upd_s) begin
            if (!attack_i) begin
                armed_d = 1'b1;
            end else begin
                armed_d = armed_q;
            end
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (attack_i && armed_q) begin
                        state_d    = S_ATTACK;
                        atk_cnt_d  = 4'd0;
                        armed_d    = 1'b0;
                        walk_cnt_d = 4'd0;
                        walk_ph_d  = 2'd0;
                    end else if (move_l_i ^ move_r_i) begin
                        state_d  = S_WALK;
                        facing_d = move_r_i;
                        if (move_r_i) begin
                            if (right_sum_s > {1'b0, X_MAX}) begin
                                pos_x_d = X_MAX;
                            end else begin
                                pos_x_d = right_sum_s[9:0];
                            end
                        end else begin
                            if ({1'b0, pos_x_q} < left_lim_s) begin
                                pos_x_d = X_MIN;
                            end else begin
                                pos_x_d = pos_x_q - STEP;
                            end
                        end
                        if (walk_cnt_q == WALK_DIV - 4'd1) begin
                            walk_cnt_d = 4'd0;
                            walk_ph_d  = walk_ph_q + 2'd1;
                        end else begin
                            walk_cnt_d = walk_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d    = S_IDLE;
                        walk_cnt_d = 4'd0;
                        walk_ph_d  = 2'd0;
                    end
                end
                S_ATTACK: begin
                    if (atk_cnt_q == ATTACK_FRAMES - 4'd1) begin
                        state_d  = S_COOL;
                        cd_cnt_d = 4'd0;
                    end else begin
                        atk_cnt_d = atk_cnt_q + 4'd1;
                    end
                end
                S_COOL: begin
                    if (cd_cnt_q == COOLDOWN_FRAMES - 4'd1) begin
                        state_d    = S_IDLE;
                        walk_cnt_d = 4'd0;
                        walk_ph_d  = 2'd0;
                    end else begin
                        cd_cnt_d = cd_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Animation index and hit window are precomputed from next state so they register alongside it.
    always_comb begin
        anim_d = 4'd0;
        case (state_d)
            S_IDLE:   anim_d = 4'd0;
            S_WALK:   anim_d = {2'b00, walk_ph_d};
            S_ATTACK: anim_d = atk_cnt_d;
            S_COOL:   anim_d = ATTACK_FRAMES - 4'd1;
            default:  anim_d = 4'd0;
        endcase
        if (state_d == S_ATTACK && atk_cnt_d >= HIT_FIRST && atk_cnt_d <= HIT_LAST) begin
            hit_d = 1'b1;
        end else begin
            hit_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pos_x_q    <= X_START;
            facing_q   <= FACING_INIT;
            armed_q    <= 1'b1;
            atk_cnt_q  <= 4'd0;
            cd_cnt_q   <= 4'd0;
            walk_cnt_q <= 4'd0;
            walk_ph_q  <= 2'd0;
            anim_q     <= 4'd0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            facing_q   <= facing_d;
            armed_q    <= armed_d;
            atk_cnt_q  <= atk_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            walk_cnt_q <= walk_cnt_d;
            walk_ph_q  <= walk_ph_d;
            anim_q     <= anim_d;
            hit_q      <= hit_d;
        end
    end

    assign pos_x_o      = pos_x_q;
    assign facing_o     = facing_q;
    assign state_o      = state_q;
    assign anim_frame_o = anim_q;
    assign hit_active_o = hit_q;
    assign busy_o       = state_q[1];
endmodule

// File: tb/tb_character_motion_fsm.sv
// Randomized and directed bench for character_motion_fsm against an
// update-count based behavioural model.
module tb_character_motion_fsm;
    localparam int X_MAX_I = 576;
    localparam int STEP_I  = 4;
    localparam int AF_I    = 8;
    localparam int CD_I    = 4;
    localparam int WDIV_I  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, en = 1'b0, ml = 1'b0, mr = 1'b0, atk = 1'b0, en_e = 1'b0;

    logic [9:0] pos;   logic face; logic [1:0] st; logic [3:0] anim; logic hit; logic busy;
    logic [9:0] l_pos; logic l_face; logic [1:0] l_st; logic [3:0] l_anim; logic l_hit; logic l_busy;
    logic [9:0] r_pos; logic r_face; logic [1:0] r_st; logic [3:0] r_anim; logic r_hit; logic r_busy;

    int checks = 0;
    int fails  = 0;

    int m_pos, m_age, m_wk;
    bit m_face, m_armed, m_seq, m_walk;

    always #5 clk = ~clk;

    character_motion_fsm dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .game_en_i(en),
        .move_l_i(ml), .move_r_i(mr), .attack_i(atk),
        .pos_x_o(pos), .facing_o(face), .state_o(st), .anim_frame_o(anim),
        .hit_active_o(hit), .busy_o(busy)
    );

    character_motion_fsm #(.X_START(10'd2)) u_left (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .game_en_i(en_e),
        .move_l_i(ml), .move_r_i(mr), .attack_i(atk),
        .pos_x_o(l_pos), .facing_o(l_face), .state_o(l_st), .anim_frame_o(l_anim),
        .hit_active_o(l_hit), .busy_o(l_busy)
    );

    character_motion_fsm #(.X_START(10'd574)) u_right (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .game_en_i(en_e),
        .move_l_i(ml), .move_r_i(mr), .attack_i(atk),
        .pos_x_o(r_pos), .facing_o(r_face), .state_o(r_st), .anim_frame_o(r_anim),
        .hit_active_o(r_hit), .busy_o(r_busy)
    );

    // Packed view: {pos_x, facing, state, anim_frame, hit_active, busy}
    wire [18:0] dut_vec = {pos, face, st, anim, hit, busy};

    task automatic model_reset();
        m_pos = 64; m_face = 1'b1; m_armed = 1'b1; m_seq = 1'b0; m_walk = 1'b0;
        m_age = 0; m_wk = 0;
    endtask

    // m_age counts updates since the attack began; the whole sequence lasts AF+CD updates.
    task automatic model_update(input bit l, input bit r, input bit a);
        bit entered = 1'b0;
        if (m_seq) begin
            m_age++;
            if (m_age >= AF_I + CD_I) begin
                m_seq = 1'b0; m_walk = 1'b0; m_wk = 0;
            end
        end else if (a && m_armed) begin
            m_seq = 1'b1; m_age = 0; m_walk = 1'b0; m_wk = 0; entered = 1'b1;
        end else if (l != r) begin
            m_walk = 1'b1; m_face = r; m_wk++;
            if (r) m_pos = (m_pos + STEP_I > X_MAX_I) ? X_MAX_I : m_pos + STEP_I;
            else   m_pos = (m_pos < STEP_I) ? 0 : m_pos - STEP_I;
        end else begin
            m_walk = 1'b0; m_wk = 0;
        end
        if (!a) m_armed = 1'b1;
        else if (entered) m_armed = 1'b0;
    endtask

    function automatic logic [18:0] model_vec();
        int s, an;
        bit h;
        s  = m_seq ? ((m_age < AF_I) ? 2 : 3) : (m_walk ? 1 : 0);
        an = m_seq ? ((m_age < AF_I) ? m_age : AF_I - 1) : (m_walk ? (m_wk / WDIV_I) % 4 : 0);
        h  = m_seq && m_age >= 3 && m_age <= 5;
        return {10'(m_pos), m_face, 2'(s), 4'(an), h, m_seq};
    endfunction

    task automatic apply(input bit t, input bit e, input bit l, input bit r, input bit a);
        tick = t; en = e; ml = l; mr = r; atk = a;
        @(posedge clk);
        #1;
        if (t && e) model_update(l, r, a);
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dut_vec !== {10'd64, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset: got=%h exp=%h", dut_vec, {10'd64, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_walk();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (pos !== 10'(64 + 4 * (i + 1)) || st !== 2'b01 || face !== 1'b1) begin
                fails++; $display("FAIL walk_right[%0d]: pos=%0d st=%0d face=%0d exp pos=%0d st=1 face=1", i, pos, st, face, 64 + 4 * (i + 1));
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL walk_model[%0d]: got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (st !== 2'b00 || anim !== 4'd0 || pos !== 10'd76) begin
            fails++; $display("FAIL walk_release: st=%0d anim=%0d pos=%0d exp st=0 anim=0 pos=76", st, anim, pos);
        end
    endtask

    task automatic test_clamp();
        int exp_r[2] = '{576, 576};
        int exp_l[4] = '{6, 2, 0, 0};
        apply_reset();
        en_e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (r_pos !== 10'(exp_r[i])) begin
                fails++; $display("FAIL clamp_right[%0d]: got=%0d exp=%0d", i, r_pos, exp_r[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (l_pos !== 10'(exp_l[i])) begin
                fails++; $display("FAIL clamp_left[%0d]: got=%0d exp=%0d", i, l_pos, exp_l[i]);
            end
        end
        en_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL clamp_main[%0d]: got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_attack();
        int hits, busies;
        apply_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (st !== 2'b10 || pos !== 10'd64 || anim !== 4'd0) begin
            fails++; $display("FAIL attack_entry: st=%0d pos=%0d anim=%0d exp st=2 pos=64 anim=0", st, pos, anim);
        end
        hits = int'(hit); busies = int'(busy);
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            hits += int'(hit); busies += int'(busy);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL attack_seq[%0d]: got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (hits != 3 || busies != 12 || st !== 2'b00) begin
            fails++; $display("FAIL attack_window: hits=%0d busy=%0d st=%0d exp hits=3 busy=12 st=0", hits, busies, st);
        end
    endtask

    task automatic test_hold_attack();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL hold_attack[%0d]: got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (st !== 2'b00) begin
            fails++; $display("FAIL hold_no_repeat: st=%0d exp=0", st);
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 2'b10) begin
            fails++; $display("FAIL rearm: st=%0d exp=2", st);
        end
    endtask

    task automatic test_both_keys();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (st !== 2'b00 || pos !== 10'd64) begin
                fails++; $display("FAIL both_keys[%0d]: st=%0d pos=%0d exp st=0 pos=64", i, st, pos);
            end
        end
    endtask

    task automatic test_game_en();
        logic [18:0] frozen;
        apply_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frozen = dut_vec;
        checks++;
        if (anim !== 4'd2 || hit !== 1'b0) begin
            fails++; $display("FAIL gate_pre: anim=%0d hit=%0d exp anim=2 hit=0", anim, hit);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec !== frozen) begin
                fails++; $display("FAIL gate_frozen[%0d]: got=%h exp=%h", i, dut_vec, frozen);
            end
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (anim !== 4'd3 || hit !== 1'b1 || st !== 2'b10) begin
            fails++; $display("FAIL gate_resume: anim=%0d hit=%0d st=%0d exp anim=3 hit=1 st=2", anim, hit, st);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== {10'd64, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL async_reset: got=%h exp=%h", dut_vec, {10'd64, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== 2'b10) begin
            fails++; $display("FAIL held_attack_after_reset: st=%0d exp=2", st);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            apply(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL random[%0d]: got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk();
        test_clamp();
        test_attack();
        test_hold_attack();
        test_both_keys();
        test_game_en();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
